// File: rtl/sq_wave_pkg.sv
// sq_wave_pkg: shared state encoding and defaults for the square-wave generator
package sq_wave_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int CWIDTH_DEF = 8;
  localparam int HALF_DEF = 2000;
  localparam int MIN_HALF = 1;
endpackage

// File: rtl/sq_wave_gen_half_period_counter.sv
// half_period_counter: reloadable down-counter, tick_out flags a zero count
module half_period_counter
  import sq_wave_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick_out
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk1) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tick_out = cnt == '0;
endmodule

// File: rtl/sq_wave_gen.sv
// sq_wave_gen: programmable square-wave source with burst length and graceful stop
module sq_wave_gen
  import sq_wave_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int HALF_DEFAULT = HALF_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_half,
  input  logic [CWIDTH-1:0] cfg_cycles,
  output logic              wave_out,
  output logic              busy,
  output logic              done,
  output logic [CWIDTH-1:0] cycle_cnt
);
  state_t state;
  logic [WIDTH-1:0] half_r, h_use;
  logic [CWIDTH-1:0] cycles_r, cnt_next;
  logic xfer, start, tick, tick_en, fall, fin, stop, load;
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign xfer = cfg_valid & cfg_ready;
  // a transfer on the start edge must already shape that run
  assign h_use = xfer ? (cfg_half == '0 ? WIDTH'(MIN_HALF) : cfg_half) : half_r;
  assign start = (state == IDLE) & en;
  assign tick_en = busy & tick;
  assign fall = tick_en & wave_out;
  assign cnt_next = cycle_cnt + 1'b1;
  assign fin = fall & (cycles_r != '0) & (cnt_next == cycles_r);
  assign stop = fall & ((state == STOP) | ~en);
  assign load = start | tick_en;
  half_period_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk1(clk1),
    .rst(rst),
    .load(load),
    .load_val(h_use - 1'b1),
    .tick_out(tick)
  );
  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= IDLE;
      wave_out <= 1'b0;
      done <= 1'b0;
      cycle_cnt <= '0;
      half_r <= WIDTH'(HALF_DEFAULT);
      cycles_r <= '0;
    end else begin
      done <= fin;
      if (xfer) begin
        half_r <= h_use;
        cycles_r <= cfg_cycles;
      end
      if (start) begin
        state <= RUN;
        cycle_cnt <= '0;
      end else if (fin | stop) state <= IDLE;
      else if (state == RUN && !en) state <= STOP;
      if (tick_en) wave_out <= ~wave_out;
      if (fall) cycle_cnt <= cnt_next;
    end
  end
endmodule

// File: tb/tb_sq_wave_gen.sv
// tb_sq_wave_gen: per-cycle scoreboard against an arithmetic model of the wave timeline
module tb_sq_wave_gen;
  logic clk1 = 1'b0, rst, en, cfg_valid, cfg_ready, wave_out, busy, done;
  logic [15:0] cfg_half;
  logic [7:0] cfg_cycles, cycle_cnt;
  int total = 0, bad = 0;
  logic [11:0] expq[$];
  int m_half, m_cycles, m_h, m_n, m_k;
  bit m_busy, m_wave, m_done, m_sreq;
  logic [7:0] m_cnt;

  sq_wave_gen dut (
    .clk1(clk1), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_half(cfg_half), .cfg_cycles(cfg_cycles), .wave_out(wave_out), .busy(busy),
    .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk1 = ~clk1;

  // Model: a run is a timeline of k cycles since busy rose; wave = odd half-period index
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_wave = 0; m_done = 0; m_cnt = 0; m_half = 2000; m_cycles = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (cfg_valid) begin
        m_half = (cfg_half == 0) ? 1 : int'(cfg_half);
        m_cycles = int'(cfg_cycles);
      end
      if (en) begin
        m_busy = 1; m_k = 0; m_h = m_half; m_n = m_cycles; m_sreq = 0; m_cnt = 0;
      end
      m_wave = 0;
    end else begin
      m_done = 0;
      m_sreq = m_sreq | !en;
      m_k++;
      m_wave = ((m_k / m_h) % 2) == 1;
      m_cnt = 8'(m_k / (2 * m_h));
      if (m_k % (2 * m_h) == 0) begin
        if (m_n != 0 && m_k / (2 * m_h) == m_n) begin
          m_busy = 0; m_done = 1;
        end else if (m_sreq) m_busy = 0;
      end
    end
    expq.push_back({m_busy, m_wave, m_done, !m_busy, m_cnt});
  endtask

  initial forever begin
    @(posedge clk1);
    model_step();
  end

  initial forever begin
    logic [11:0] e, a;
    @(negedge clk1);
    if (expq.size() != 0) begin
      e = expq.pop_front();
      a = {busy, wave_out, done, cfg_ready, cycle_cnt};
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 30)
          $display("FAIL outputs t=%0t {busy,wave,done,ready,cnt} got=%b_%b_%b_%b_%0d exp=%b_%b_%b_%b_%0d",
                   $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step(1);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, budget);
    end
  endtask

  initial begin
    rst = 1; en = 0; cfg_valid = 0; cfg_half = 0; cfg_cycles = 0;
    step(2);
    rst = 0;
    step(1);
    // default half-period, free-run across two full periods
    en = 1; step(8010);
    en = 0; wait_idle(5000);
    step(2);
    // finite burst of two periods with H=3
    cfg_valid = 1; cfg_half = 3; cfg_cycles = 2; step(1);
    cfg_valid = 0; en = 1; wait_idle(50);
    en = 0; step(3);
    // zero half-period coerced to one, config and start on the same edge
    cfg_valid = 1; cfg_half = 0; cfg_cycles = 3; en = 1; step(1);
    cfg_valid = 0; wait_idle(50);
    en = 0; step(3);
    // graceful stop during the high phase
    cfg_valid = 1; cfg_half = 5; cfg_cycles = 0; step(1);
    cfg_valid = 0; en = 1; step(8);
    en = 0; wait_idle(50);
    step(3);
    // offer held off while busy, accepted once idle
    cfg_valid = 1; cfg_half = 4; cfg_cycles = 0; en = 1; step(1);
    cfg_half = 7; cfg_cycles = 1; step(10);
    en = 0; wait_idle(50);
    step(1);
    cfg_valid = 0; en = 1; wait_idle(100);
    en = 0; step(3);
    // reset while wave_out is high restores the default half-period
    cfg_valid = 1; cfg_half = 7; cfg_cycles = 0; step(1);
    cfg_valid = 0; en = 1;
    for (int i = 0; i < 50 && !wave_out; i++) step(1);
    total++;
    if (!wave_out) begin
      bad++;
      $display("FAIL wait_high wave_out=%b required=1", wave_out);
    end
    rst = 1; en = 0; step(1);
    rst = 0; step(2);
    en = 1; step(2010);
    en = 0; wait_idle(5000);
    step(2);
    // randomized runs with random stop points and stray offers
    repeat (40) begin
      cfg_valid = 1; cfg_half = 16'($urandom_range(0, 6)); cfg_cycles = 8'($urandom_range(0, 4));
      en = 1'($urandom_range(0, 1)); step(1);
      cfg_valid = 1'($urandom_range(0, 1)); cfg_half = 16'($urandom_range(0, 20)); en = 1;
      step($urandom_range(1, 30));
      en = 0; step($urandom_range(0, 3));
      en = 1'($urandom_range(0, 1)); cfg_valid = 0;
      wait_idle(200);
      en = 0; step(2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sq_wave_gen.md
Name: sq_wave_gen

Overview:
Programmable square-wave stimulus source. Its wave_out drives the input of the CMOS inverter stage, replacing the free-running testbench toggle on that input with a synthesizable generator. Provides a configurable half-period, an optional finite burst length, and a start/stop handshake, so inverter characterisation runs are repeatable and self-terminating.

Parameters:
WIDTH, 16, bit width of the half-period count.
CWIDTH, 8, bit width of the burst-length count.
HALF_DEFAULT, 2000, half-period in clk1 cycles after reset.

Ports:
clk1  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  level; start request in IDLE; graceful stop when dropped while running
cfg_valid  input  1  configuration offer
cfg_ready  output  1  high only in IDLE; transfer occurs when cfg_valid & cfg_ready
cfg_half  input  WIDTH  new half-period in cycles; 0 is coerced to 1
cfg_cycles  input  CWIDTH  burst length in full periods; 0 = free-run
wave_out  output  1  square wave to the inverter input (registered)
busy  output  1  high in RUN and STOP
done  output  1  one-cycle pulse when a finite burst completes
cycle_cnt  output  CWIDTH  full periods completed in the current run

Behaviour:
- Interface: one clock (clk1); reset rst is synchronous, active-high.
- Reset values (next edge with rst=1, from any state, including mid-run): state=IDLE, wave_out=0, busy=0, done=0, cycle_cnt=0, cfg_ready=1, half register=HALF_DEFAULT, cycles register=0, down-counter=0.
- States: IDLE, RUN, STOP.
- IDLE: cfg_ready=1. A cfg transfer loads the half and cycles registers. If cfg transfer and en=1 occur on the same edge, the new config is used for that run.
- IDLE->RUN when en=1. On that edge: down-counter=half-1, cycle_cnt=0, busy=1, wave_out stays 0.
- RUN/STOP tick: counter!=0 -> decrement. Counter==0 -> toggle wave_out and reload half-1.
- Result: wave_out high H cycles, low H cycles, period 2H. The first rising edge of wave_out follows exactly H cycles after busy asserts.
- Falling toggle (1->0) completes one period; cycle_cnt increments with wrap modulo 2^CWIDTH. Wrap is only reachable in free-run mode.
- Finite burst: on the falling toggle where cycle_cnt+1==cycles -> IDLE, busy=0, done=1 for exactly one cycle. cycle_cnt holds its final value until the next start.
- RUN with en=0 -> STOP. STOP continues toggling until the next falling toggle, then IDLE, busy=0, no done pulse. If en=0 while wave_out is low and the counter is mid-low-phase, the low phase completes, then one high phase runs, then falling toggle -> IDLE. The final period is always complete.
- Burst completion and en=0 on the same falling edge: done is asserted (burst completion wins).
- H=1: wave_out toggles every cycle (period 2).
- cfg_valid while busy: cfg_ready=0, the offer is held off, and registers are unchanged.
- wave_out is always low in IDLE (glitch-free stop).

Decomposition:
- Shared package sq_wave_pkg: state enum (IDLE, RUN, STOP), HALF_DEFAULT, WIDTH and CWIDTH defaults, MIN_HALF=1.
- One natural sub-module: half_period_counter.
  - Ports: clk1, rst, load, load_val, tick_out.
  - Function: down-counter with reload; tick_out=1 when the count is 0 while enabled.
- The FSM, wave register and cycle counter live in sq_wave_gen.

Test Plan:
1. Reset then en=1 with default config -> busy at +1 cycle; wave_out rises at +2000 cycles, falls at +4000; cycle_cnt=1 at the fall; free-runs.
2. cfg_half=3, cfg_cycles=2, then en=1 -> wave_out pattern 000111000111 then IDLE; done pulses once on the 2nd fall; cycle_cnt=2; busy drops the same edge.
3. cfg_half=0 -> behaves as 1; wave_out toggles every cycle; period 2.
4. cfg_half=5 free-run; drop en during the high phase -> high completes, falls, IDLE; no done; wave_out=0; cfg_ready=1.
5. Assert cfg_valid with cfg_half=7 while busy -> cfg_ready=0 and the half-period is unchanged. After returning to IDLE the transfer completes, and the next run uses 7.
6. rst=1 mid-run at wave_out=1 -> next edge: wave_out=0, busy=0, cycle_cnt=0, half=2000.
